floating_point_sqrt: RTL and testbench

FLOATING_POINT_SQRT -- requirements
Module: floating_point_sqrt

---
 rtl/fp_sqrt_pkg.sv | 35 +++
 rtl/isqrt_unit.sv | 42 ++++
 rtl/floating_point_sqrt.sv | 154 +++++++++++++++
 tb/tb_floating_point_sqrt.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and sizing for the floating-point square root.
// FP_SQRT_ROUND_EN adds one extra root bit for round-to-nearest.
package fp_sqrt_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 7;
  localparam logic [EXP_W-1:0] ZERO_EXP = 8'h80;

`ifdef FP_SQRT_ROUND_EN
  localparam int unsigned ITERS = 9;
`else
  localparam int unsigned ITERS = 8;
`endif

  localparam int unsigned ROOT_W = ITERS;
  localparam int unsigned RAD_W  = 2 * ITERS;
  localparam int unsigned REM_W  = ITERS + 2;
  // Significand with one spare bit for the odd-exponent left shift
  localparam int unsigned SIG_W  = MAN_W + 2;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/isqrt_unit.sv
// Iterative restoring integer square root, one root bit per step.
module isqrt_unit
  import fp_sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [RAD_W-1:0]  radicand,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem
);

  logic [RAD_W-1:0] rad_q;
  logic [REM_W-1:0] rem_sh_c;
  logic [REM_W-1:0] trial_c;
  logic             fits_c;

  // Bring down the next two radicand bits and test 4*root+1 against them
  always_comb begin
    rem_sh_c = {rem[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    trial_c  = {root, 2'b01};
    fits_c   = (rem_sh_c >= trial_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q <= '0;
      root  <= '0;
      rem   <= '0;
    end else if (load) begin
      rad_q <= radicand;
      root  <= '0;
      rem   <= '0;
    end else if (step) begin
      rad_q <= {rad_q[RAD_W-3:0], 2'b00};
      root  <= {root[ROOT_W-2:0], fits_c};
      rem   <= fits_c ? (rem_sh_c - trial_c) : rem_sh_c;
    end
  end

endmodule

// File: rtl/floating_point_sqrt.sv
// Square root of a 16-bit unbiased-exponent float: FSM, exponent halving and result packing.
// Define FP_SQRT_ROUND_EN for round-to-nearest instead of truncation.
module floating_point_sqrt
  import fp_sqrt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sqrt_start,
  input  logic [15:0] num_i,
  output logic [15:0] res_o,
  output logic        valid_o,
  output logic        error_o
);

  state_t            state;
  state_t            state_nxt;
  fp16_t             num_q;
  logic [EXP_W-1:0]  exp_q;
  logic              zero_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept_c;
  logic              load_c;
  logic              step_c;
  logic              op_zero_c;
  logic              op_neg_c;
  logic [SIG_W-1:0]  sig_c;
  logic [RAD_W-1:0]  rad_c;
  fp16_t             res_c;
  logic              err_c;
  logic              unused_c;

  logic [ROOT_W-1:0] root;
  logic [REM_W-1:0]  rem;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    load_c    = 1'b0;
    step_c    = 1'b0;
    unique case (state)
      IDLE: if (sqrt_start) begin
        accept_c  = 1'b1;
        state_nxt = PREP;
      end
      PREP: begin
        load_c    = 1'b1;
        state_nxt = (op_zero_c || op_neg_c) ? DONE : ITER;
      end
      ITER: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) state_nxt = DONE;
      end
      DONE: if (sqrt_start) begin
        accept_c  = 1'b1;
        state_nxt = PREP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero wins over sign; an odd exponent folds one factor of 2 into the significand
  always_comb begin
    op_zero_c = (num_q.exp == ZERO_EXP);
    op_neg_c  = num_q.sign && !op_zero_c;
    sig_c     = num_q.exp[0] ? {1'b1, num_q.man, 1'b0} : {1'b0, 1'b1, num_q.man};
    rad_c     = {sig_c, {(RAD_W - SIG_W){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept_c) num_q <= fp16_t'(num_i);
      if (load_c) begin
        exp_q  <= EXP_W'($signed(num_q.exp) >>> 1);
        zero_q <= op_zero_c;
        neg_q  <= op_neg_c;
        cnt_q  <= '0;
      end else if (step_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  isqrt_unit u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .step     (step_c),
    .radicand (rad_c),
    .root     (root),
    .rem      (rem)
  );

  // Remainder and the always-set root MSB carry no result information
  assign unused_c = ^{rem, root[ROOT_W-1]};

`ifdef FP_SQRT_ROUND_EN
  logic [ROOT_W-1:0] rnd_c;
`endif

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
`ifdef FP_SQRT_ROUND_EN
    rnd_c = {1'b0, root[ROOT_W-1:1]} + ROOT_W'(root[0]);
`endif
    if (neg_q) begin
      err_c = 1'b1;
    end else if (zero_q) begin
      res_c.exp = ZERO_EXP;
    end else begin
`ifdef FP_SQRT_ROUND_EN
      if (rnd_c[ROOT_W-1]) begin
        res_c.exp = exp_q + EXP_W'(1);
      end else begin
        res_c.exp = exp_q;
        res_c.man = rnd_c[MAN_W-1:0];
      end
`else
      res_c.exp = exp_q;
      res_c.man = root[MAN_W-1:0];
`endif
    end
  end

  // Result publishes one cycle into DONE; a new request drops valid immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      res_o   <= '0;
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end else if (state == DONE && !sqrt_start) begin
      res_o   <= res_c;
      valid_o <= 1'b1;
      error_o <= err_c;
    end else begin
      valid_o <= 1'b0;
      error_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_floating_point_sqrt.sv
// Randomized bench for floating_point_sqrt against an arithmetic reference model.
module tb_floating_point_sqrt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sqrt_start = 1'b0;
  logic [15:0] num_i = '0;
  logic [15:0] res_o;
  logic        valid_o;
  logic        error_o;

`ifdef FP_SQRT_ROUND_EN
  localparam int NORM_LAT = 11;
`else
  localparam int NORM_LAT = 10;
`endif

  always #5 clk = ~clk;

  floating_point_sqrt dut (
    .clk        (clk),
    .rst        (rst),
    .sqrt_start (sqrt_start),
    .num_i      (num_i),
    .res_o      (res_o),
    .valid_o    (valid_o),
    .error_o    (error_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc     = 0;
  int          lat     = 0;
  bit          op_active = 1'b0;
  bit          fresh     = 1'b1;
  logic [15:0] exp_res = '0;
  logic        exp_err = 1'b0;

  function automatic longint isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Returns {error, result} from the number-format rules
  function automatic logic [16:0] model(input logic [15:0] n);
    int     e;
    int     re;
    longint m;
    longint r;
    e = int'($signed(n[14:7]));
    if (e == -128) return {1'b0, 16'h4000};
    if (n[15]) return {1'b1, 16'h0000};
    m = 128 + longint'(n[6:0]);
    if (e % 2 != 0) begin
      m  = m * 2;
      re = (e - 1) / 2;
    end else begin
      re = e / 2;
    end
`ifdef FP_SQRT_ROUND_EN
    r = (isqrt(m * 512) + 1) / 2;
    if (r == 256) begin
      r = 128;
      re++;
    end
`else
    r = isqrt(m * 128);
`endif
    return {1'b0, 1'b0, 8'(re), 7'(r - 128)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Track which request the DUT must accept and when its answer is due
  always @(posedge clk) begin
    logic [16:0] m;
    cyc++;
    if (rst) begin
      op_active = 1'b0;
      fresh     = 1'b1;
    end else if (sqrt_start && (!op_active || cyc >= acc + lat)) begin
      m         = model(num_i);
      exp_err   = m[16];
      exp_res   = m[15:0];
      acc       = cyc;
      op_active = 1'b1;
      lat       = (num_i[14:7] == 8'h80 || num_i[15]) ? 2 : NORM_LAT;
    end
    if (op_active && cyc >= acc + lat) fresh = 1'b0;
  end

  always @(negedge clk) begin
    bit ev;
    if (cyc > 0) begin
      ev = op_active && (cyc >= acc + lat);
      chk("valid_o", 32'(valid_o), 32'(ev));
      if (ev) begin
        chk("res_o", 32'(res_o), 32'(exp_res));
        chk("error_o", 32'(error_o), 32'(exp_err));
      end else begin
        chk("error_o_idle", 32'(error_o), 32'd0);
        if (fresh) chk("res_o_after_reset", 32'(res_o), 32'd0);
      end
    end
  end

  task automatic start(input logic [15:0] n);
    @(negedge clk);
    num_i      = n;
    sqrt_start = 1'b1;
    @(negedge clk);
    sqrt_start = 1'b0;
  endtask

  task automatic run(input logic [15:0] n);
    start(n);
    repeat (NORM_LAT + 2) @(negedge clk);
  endtask

  initial begin
    int          w;
    logic [15:0] n;

    chk("model_36",   32'(model(16'h0290)), 32'h0_0140);
    chk("model_25",   32'(model(16'h0248)), 32'h0_0120);
    chk("model_2",    32'(model(16'h0080)), 32'h0_0035);
    chk("model_0p25", 32'(model(16'h7F00)), 32'h0_7F80);
    chk("model_zero", 32'(model(16'hC000)), 32'h0_4000);
    chk("model_neg4", 32'(model(16'h8100)), 32'h1_0000);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(16'h0290);
    run(16'h0248);
    run(16'h0080);
    run(16'h7F00);
    run(16'h4000);
    run(16'hC000);
    run(16'h8100);
    run(16'h7FFF);
    run(16'h4080);

    // Re-pulse while busy must be ignored
    start(16'h0290);
    repeat (4) @(negedge clk);
    num_i = 16'h0248;
    sqrt_start = 1'b1;
    @(negedge clk);
    sqrt_start = 1'b0;
    repeat (NORM_LAT) @(negedge clk);

    // Reset mid-operation aborts silently
    start(16'h0248);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (NORM_LAT + 3) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      n = 16'($urandom);
      if ($urandom_range(0, 7) == 0) n[14:7] = 8'h80;
      start(n);
      w = int'($urandom_range(0, 14));
      for (int k = 0; k < w; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) begin
          num_i      = 16'($urandom);
          sqrt_start = 1'b1;
        end else begin
          sqrt_start = 1'b0;
        end
        rst = ($urandom_range(0, 99) == 0);
      end
      sqrt_start = 1'b0;
      rst        = 1'b0;
    end
    repeat (NORM_LAT + 3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
